pingpong_ctrl: RTL
==================

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL provide parameter TILE_W, default 8, width of the tile-count input and the internal tile counter.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  FSM advance enable; when low the FSM holds its state and all output pulses are 0.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a run.
REQ-006 SHALL have port abort  input  1  synchronous abort, honoured regardless of enable.
REQ-007 SHALL have port tile_cnt  input  TILE_W  number of tiles in the run, sampled on accepted start.
REQ-008 SHALL have port dma_w_last  input  1  pulse: input tile fully written into the ifmap buffer.
REQ-009 SHALL have port comp_done  input  1  pulse: compute engine has finished the current tile.
REQ-010 SHALL have port dma_r_last  input  1  pulse: result readback DMA has finished.
REQ-011 SHALL have port conv_en  output  1  bank-swap pulse to the ifmap buffer.
REQ-012 SHALL have port comp_start  output  1  pulse that starts the compute engine.
REQ-013 SHALL have port w_done  output  1  pulse that arms buffer readback.
REQ-014 SHALL have port bank_sel  output  1  current compute bank, 0 = bank0, 1 = bank1.
REQ-015 SHALL have port busy  output  1  run in progress.
REQ-016 SHALL have port done  output  1  single-cycle run-complete pulse.
REQ-017 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-018 SHALL implement the states IDLE, LOAD, SWAP, COMPUTE, RDBK and FIN; state advances only in cycles where enable=1, except abort.
REQ-019 SHALL latch each of dma_w_last, comp_done and dma_r_last into its own event flag (ld_f, cd_f, rd_f) in any state and regardless of enable; a flag clears when its event is consumed, and a set in the same cycle as a clear leaves the flag at 1.
REQ-020 SHALL, in IDLE with start=1 and tile_cnt!=0: capture tile_cnt, clear the tile counter, set busy on the next edge, and go to LOAD.
REQ-021 SHALL, in IDLE with start=1 and tile_cnt==0: pulse done for one cycle, keep busy=0, and stay in IDLE.
REQ-022 SHALL, in LOAD with ld_f=1: clear ld_f and go to SWAP.
REQ-023 SHALL spend exactly one enabled cycle in SWAP with conv_en=1, toggle bank_sel at the exit edge, and then go to COMPUTE.
REQ-024 SHALL assert comp_start for the first enabled cycle in COMPUTE only; in COMPUTE with cd_f=1 it SHALL clear cd_f and go to RDBK.
REQ-025 SHALL assert w_done for the first enabled cycle in RDBK only; in RDBK with rd_f=1 it SHALL clear rd_f.
REQ-026 SHALL, on that RDBK exit, go to FIN if the tile counter equals tile_cnt-1; otherwise it SHALL increment the tile counter and go to LOAD.
REQ-027 SHALL, in FIN, pulse done for one cycle, clear busy on the same edge, and return to IDLE.
REQ-028 SHALL decode conv_en, comp_start, w_done and done as Moore outputs from registered state; each is high for at most one cycle per occurrence.
REQ-029 SHALL ignore start while busy=1 and set err.
REQ-030 SHALL set err when an event pulse arrives while its flag is already 1 (the pulse is otherwise dropped).
REQ-031 SHALL set err when comp_done or dma_r_last arrives while in IDLE; in that case the flag is not set.
REQ-032 SHALL, on abort=1: go to IDLE on the next edge, clear the event flags, tile counter and busy, and produce no done; bank_sel and err keep their values.
REQ-033 SHALL clear err only by reset or by an accepted start.
REQ-034 SHALL handle abort and start asserted in the same cycle by giving abort priority.

Reset
REQ-035 SHALL, while rstn=0, force state=IDLE, bank_sel=0, busy=0, err=0, all flags and the tile counter to 0, and every pulse output to 0.
REQ-036 SHALL honour a reset asserted mid-run immediately, without completing any pending handshake.

Verification
REQ-037 SHALL cover: tile_cnt=2, events in order -> 2 conv_en pulses, bank_sel 0->1->0, done exactly once, busy low the cycle after done.
REQ-038 SHALL cover: dma_w_last for tile 1 arriving during COMPUTE of tile 0 -> ld_f held, and LOAD->SWAP takes 1 cycle after RDBK exit.
REQ-039 SHALL cover: start with tile_cnt=0 -> done on the next cycle, busy stays 0, conv_en never asserts.
REQ-040 SHALL cover: enable held low for 5 cycles in SWAP -> conv_en=0 during the stall and exactly one conv_en pulse once enable returns.
REQ-041 SHALL cover: double dma_w_last with no intervening SWAP, and start while busy -> err=1 and the run still completes normally.
REQ-042 SHALL cover: abort in COMPUTE with tile_cnt=3 -> IDLE next cycle, busy=0, no done, and a following start runs 3 tiles cleanly with err=0.

Source files
------------

// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: sequences a double-buffered (ping-pong) tile pipeline.
// For each tile: wait for the ifmap write (LOAD), swap banks (SWAP),
// run compute (COMPUTE), read back results (RDBK); after the last tile
// pulse done (FIN).
// Ports:
//   clk, rstn                 clock, async active-low reset
//   enable                    FSM advance enable (pulses gated off when low)
//   start, abort, tile_cnt    run control
//   dma_w_last, comp_done,
//   dma_r_last                completion events, latched into flags
//   conv_en, comp_start,
//   w_done, done              single-cycle pulses
//   bank_sel, busy, err       status
module pingpong_ctrl #(
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] tile_cnt,
  input  logic              dma_w_last,
  input  logic              comp_done,
  input  logic              dma_r_last,
  output logic              conv_en,
  output logic              comp_start,
  output logic              w_done,
  output logic              bank_sel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SWAP, S_COMP, S_RDBK, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   cnt_q, cnt_d, tcnt_q, tcnt_d;
  logic                ld_q, ld_d, cd_q, cd_d, rd_q, rd_d;
  logic                bank_q, bank_d, busy_q, busy_d, err_q, err_d;
  logic                first_q, first_d, zdone_q, zdone_d;
  logic                ld_clr, cd_clr, rd_clr, start_ok, idle;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    bank_d   = bank_q;
    busy_d   = busy_q;
    err_d    = err_q;
    idle     = (state_q == S_IDLE);
    ld_clr   = enable && (state_q == S_LOAD) && ld_q;
    cd_clr   = enable && (state_q == S_COMP) && cd_q;
    rd_clr   = enable && (state_q == S_RDBK) && rd_q;
    start_ok = enable && start && idle;

    // Accepted start clears err; any protocol error in the same cycle wins.
    if (start_ok) err_d = 1'b0;
    if (start && busy_q) err_d = 1'b1;

    // Event flags: a pulse landing on an unconsumed flag is an error.
    // compute/readback completions make no sense while idle.
    ld_d = (ld_q && !ld_clr) || dma_w_last;
    if (dma_w_last && ld_q && !ld_clr) err_d = 1'b1;
    cd_d = (cd_q && !cd_clr) || (comp_done && !idle);
    if (comp_done && (idle || (cd_q && !cd_clr))) err_d = 1'b1;
    rd_d = (rd_q && !rd_clr) || (dma_r_last && !idle);
    if (dma_r_last && (idle || (rd_q && !rd_clr))) err_d = 1'b1;

    // Zero-tile run: done is held pending until an enabled cycle shows it.
    zdone_d = zdone_q && !enable;
    if (start_ok && (tile_cnt == '0)) zdone_d = 1'b1;

    if (enable) begin
      case (state_q)
        S_IDLE: if (start && (tile_cnt != '0)) begin
          tcnt_d  = tile_cnt;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
        S_LOAD: if (ld_q) state_d = S_SWAP;
        S_SWAP: begin
          bank_d  = ~bank_q;
          state_d = S_COMP;
        end
        S_COMP: if (cd_q) state_d = S_RDBK;
        S_RDBK: if (rd_q) begin
          if (cnt_q == tcnt_q - TILE_W'(1)) state_d = S_FIN;
          else begin
            cnt_d   = cnt_q + TILE_W'(1);
            state_d = S_LOAD;
          end
        end
        S_FIN: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // first_q marks the first enabled cycle of a state (comp_start/w_done).
    first_d = (state_d != state_q) ? 1'b1 : (enable ? 1'b0 : first_q);

    // Abort overrides everything except bank_sel and err.
    if (abort) begin
      state_d = S_IDLE;
      ld_d    = 1'b0;
      cd_d    = 1'b0;
      rd_d    = 1'b0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      zdone_d = 1'b0;
      err_d   = err_q;
      bank_d  = bank_q;
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      ld_q    <= 1'b0;
      cd_q    <= 1'b0;
      rd_q    <= 1'b0;
      bank_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b1;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      ld_q    <= ld_d;
      cd_q    <= cd_d;
      rd_q    <= rd_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      first_q <= first_d;
      zdone_q <= zdone_d;
    end
  end

  // Pulses decode from registered state and are suppressed while stalled.
  assign conv_en    = enable && (state_q == S_SWAP);
  assign comp_start = enable && first_q && (state_q == S_COMP);
  assign w_done     = enable && first_q && (state_q == S_RDBK);
  assign done       = enable && ((state_q == S_FIN) || zdone_q);
  assign bank_sel   = bank_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
